// File: rtl/ram_sdp_sync.sv
// ram_sdp_sync: single-clock simple-dual-port RAM with one write port and one
// registered read port. After reset, a clear sequencer writes CLEAR_VALUE to
// every location before user accesses are accepted. Same-address read/write
// in one cycle returns the pre-write data.
// Build option: define RAM_SDP_PIPE_EN to add a second output register stage
// (read latency 2 instead of 1, throughput unchanged).
module ram_sdp_sync #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  init_busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_fire;

  // Sequencer next state and write-port steering: the clear sequencer owns the
  // write port in CLEAR, the user owns it in RUN; reads only fire in RUN.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy_d     = busy_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;
    rd_fire    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = CLEAR_VALUE;
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == '1) begin
          state_d = RUN;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        mem_we  = wr_en;
        rd_fire = rd_en;
      end
      default: begin
        state_d = CLEAR;
        busy_d  = 1'b1;
      end
    endcase
  end

  // Read register next state: the array is read combinationally before the
  // same edge's write lands, which yields read-before-write on collisions.
  always_comb begin
    rd_valid_d = rd_fire;
    rd_data_d  = rd_data_q;
    if (rd_fire) begin
      rd_data_d = mem[rd_addr];
    end
  end

  // FSM, clear counter and first read stage; reset drops any in-flight read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage array write port; contents are only initialised by the sequencer.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign init_busy = busy_q;

`ifdef RAM_SDP_PIPE_EN
  logic [DATA_WIDTH-1:0] pipe_data_q;
  logic                  pipe_valid_q;

  // Output pipeline stage; data only moves with a valid result so it holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_data_q  <= '0;
      pipe_valid_q <= 1'b0;
    end else begin
      pipe_valid_q <= rd_valid_q;
      if (rd_valid_q) begin
        pipe_data_q <= rd_data_q;
      end
    end
  end

  assign rd_data  = pipe_data_q;
  assign rd_valid = pipe_valid_q;
`else
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_ram_sdp_sync.sv
// Bench for ram_sdp_sync: three instances (18x16, 1x4, 36x1024) share clock and
// reset. A behavioural memory model predicts init_busy, rd_valid and rd_data
// every cycle; directed reads pin the model with literal expectations.
module tb_ram_sdp_sync;

`ifdef RAM_SDP_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NI = 3;

  localparam logic [17:0] CV0 = 18'h2A5;
  localparam logic [0:0]  CV1 = 1'b1;
  localparam logic [35:0] CV2 = 36'h9_C3A5_5A3C;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en   [NI];
  logic        rd_en   [NI];
  logic [9:0]  wr_addr [NI];
  logic [9:0]  rd_addr [NI];
  logic [35:0] wr_data [NI];
  logic        busy    [NI];
  logic        rd_valid[NI];
  logic [35:0] rd_data [NI];

  logic [17:0] rd_data0;
  logic [0:0]  rd_data1;
  logic [35:0] rd_data2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_sdp_sync #(.DATA_WIDTH(18), .ADDR_WIDTH(4), .CLEAR_VALUE(CV0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .init_busy(busy[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0][3:0]), .wr_data(wr_data[0][17:0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0][3:0]),
    .rd_data(rd_data0), .rd_valid(rd_valid[0]));

  ram_sdp_sync #(.DATA_WIDTH(1), .ADDR_WIDTH(2), .CLEAR_VALUE(CV1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .init_busy(busy[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1][1:0]), .wr_data(wr_data[1][0:0]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1][1:0]),
    .rd_data(rd_data1), .rd_valid(rd_valid[1]));

  ram_sdp_sync #(.DATA_WIDTH(36), .ADDR_WIDTH(10), .CLEAR_VALUE(CV2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .init_busy(busy[2]),
    .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]),
    .rd_en(rd_en[2]), .rd_addr(rd_addr[2]),
    .rd_data(rd_data2), .rd_valid(rd_valid[2]));

  assign rd_data[0] = {18'b0, rd_data0};
  assign rd_data[1] = {35'b0, rd_data1};
  assign rd_data[2] = rd_data2;

  function automatic int dw(int g);
    return (g == 0) ? 18 : (g == 1) ? 1 : 36;
  endfunction

  function automatic int aw(int g);
    return (g == 0) ? 4 : (g == 1) ? 2 : 10;
  endfunction

  function automatic logic [35:0] cv(int g);
    return (g == 0) ? {18'b0, CV0} : (g == 1) ? {35'b0, CV1} : CV2;
  endfunction

  function automatic logic [35:0] dmask(int g);
    logic [36:0] t;
    t = (37'h1 << dw(g)) - 37'h1;
    return t[35:0];
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    int          inst;
    longint      due;
    logic [35:0] data;
  } pend_t;

  logic [35:0] mm [NI][1024];
  int          since[NI];
  longint      cyc = 0;
  logic        exp_valid[NI];
  logic [35:0] exp_data [NI];
  pend_t       pend[$];

  // Model: a location is cleared per cycle after reset release, then reads
  // capture the pre-write contents and become visible LAT-1 edges later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend.delete();
      for (int g = 0; g < NI; g++) begin
        since[g]     = 0;
        exp_valid[g] = 1'b0;
        exp_data[g]  = '0;
      end
    end else begin
      cyc++;
      for (int g = 0; g < NI; g++) begin
        int depth;
        depth = 1 << aw(g);
        if (since[g] < depth) begin
          mm[g][since[g]] = cv(g);
          since[g]++;
        end else begin
          if (rd_en[g])
            pend.push_back('{inst: g, due: cyc + LAT - 1,
                             data: mm[g][int'(rd_addr[g]) & (depth - 1)]});
          if (wr_en[g])
            mm[g][int'(wr_addr[g]) & (depth - 1)] = wr_data[g] & dmask(g);
        end
      end
      for (int g = 0; g < NI; g++) exp_valid[g] = 1'b0;
      foreach (pend[i]) begin
        if (pend[i].due == cyc) begin
          exp_valid[pend[i].inst] = 1'b1;
          exp_data[pend[i].inst]  = pend[i].data;
        end
      end
      while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int g, input int a, input logic [35:0] d);
    wr_en[g] = 1'b1; wr_addr[g] = 10'(a); wr_data[g] = d;
    tick();
    wr_en[g] = 1'b0;
  endtask

  task automatic read_check(input int g, input int a, input logic [35:0] exp, input string name);
    rd_en[g] = 1'b1; rd_addr[g] = 10'(a);
    tick();
    rd_en[g] = 1'b0;
    repeat (LAT - 1) tick();
    #1;
    chk({name, "_valid"}, {35'b0, rd_valid[g]}, 36'd1);
    chk(name, rd_data[g], exp);
  endtask

  task automatic count_busy(output int n, output logic sawv);
    n = 0;
    sawv = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rd_valid[0]) sawv = 1'b1;
      if (!busy[0]) break;
      n++;
    end
  endtask

  function automatic logic [9:0] pick(int g);
    int depth;
    int r;
    depth = 1 << aw(g);
    r = int'($urandom % 4);
    if (r == 0) return 10'(depth - 1);
    if (r == 1) return 10'd0;
    return 10'($urandom % depth);
  endfunction

  // ---------------- stimulus and checking ----------------
  initial begin
    int          n;
    logic        sawv;
    int          nval;
    logic [35:0] cap[2];

    reset_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      wr_en[g] = 1'b0; rd_en[g] = 1'b0;
      wr_addr[g] = '0; rd_addr[g] = '0; wr_data[g] = '0;
    end

    fork
      forever begin
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
          chk($sformatf("model_busy%0d", g), {35'b0, busy[g]},
              {35'b0, since[g] < (1 << aw(g))});
          chk($sformatf("model_valid%0d", g), {35'b0, rd_valid[g]}, {35'b0, exp_valid[g]});
          chk($sformatf("model_data%0d", g), rd_data[g], exp_data[g]);
        end
      end
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
      end
    join_none

    repeat (3) tick();
    #1;
    chk("reset_busy", {35'b0, busy[0]}, 36'd1);
    chk("reset_valid", {35'b0, rd_valid[0]}, 36'd0);
    chk("reset_data", rd_data[0], 36'd0);

    // Clear sequence with user accesses attempted during it
    wr_en[0] = 1'b1; wr_addr[0] = 10'd0; wr_data[0] = 36'd1;
    rd_en[0] = 1'b1; rd_addr[0] = 10'd0;
    reset_n = 1'b1;
    count_busy(n, sawv);
    wr_en[0] = 1'b0; rd_en[0] = 1'b0;
    chk("clear_cycles", 36'(n), 36'd16);
    chk("no_valid_in_clear", {35'b0, sawv}, 36'd0);

    // Read every location back-to-back
    for (int a = 0; a < 16; a++) begin
      rd_en[0] = 1'b1; rd_addr[0] = 10'(a);
      tick();
    end
    rd_en[0] = 1'b0;
    read_check(0, 0, 36'h2A5, "clear_addr0");
    read_check(0, 15, 36'h2A5, "clear_addr15");

    // Basic write then consecutive reads
    wr(0, 5, 36'h3FFFF);
    wr(0, 6, 36'h00001);
    rd_en[0] = 1'b1; rd_addr[0] = 10'd5;
    nval = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) rd_addr[0] = 10'd6;
      if (i == 1) rd_en[0] = 1'b0;
      #1;
      if (rd_valid[0]) begin
        if (nval < 2) cap[nval] = rd_data[0];
        nval++;
      end
    end
    chk("b2b_valid_cycles", 36'(nval), 36'd2);
    chk("b2b_first", cap[0], 36'h3FFFF);
    chk("b2b_second", cap[1], 36'h00001);

    // Same-address collision returns the old data
    wr(0, 7, 36'h00111);
    wr_en[0] = 1'b1; wr_addr[0] = 10'd7; wr_data[0] = 36'h00222;
    rd_en[0] = 1'b1; rd_addr[0] = 10'd7;
    tick();
    wr_en[0] = 1'b0; rd_en[0] = 1'b0;
    repeat (LAT - 1) tick();
    #1;
    chk("collision_old", rd_data[0], 36'h00111);
    read_check(0, 7, 36'h00222, "collision_new");

    // Different-address write and read in one cycle
    wr_en[0] = 1'b1; wr_addr[0] = 10'd8; wr_data[0] = 36'h0AAAA;
    rd_en[0] = 1'b1; rd_addr[0] = 10'd5;
    tick();
    wr_en[0] = 1'b0; rd_en[0] = 1'b0;
    repeat (LAT - 1) tick();
    #1;
    chk("indep_read", rd_data[0], 36'h3FFFF);
    read_check(0, 8, 36'h0AAAA, "indep_write");
    tick(); tick();
    #1;
    chk("hold_valid", {35'b0, rd_valid[0]}, 36'd0);
    chk("hold_data", rd_data[0], 36'h0AAAA);

    // Reset during an in-flight read
    rd_en[0] = 1'b1; rd_addr[0] = 10'd6;
    tick();
    rd_en[0] = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_read_valid", {35'b0, rd_valid[0]}, 36'd0);
    chk("rst_read_data", rd_data[0], 36'd0);
    chk("rst_read_busy", {35'b0, busy[0]}, 36'd1);
    tick();
    reset_n = 1'b1;
    count_busy(n, sawv);
    chk("rst_read_clear_cycles", 36'(n), 36'd16);
    read_check(0, 6, 36'h2A5, "rst_read_cleared");

    // Reset in the middle of the clear sequence
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    tick();
    reset_n = 1'b0;
    #1;
    chk("rst_clear_busy", {35'b0, busy[0]}, 36'd1);
    tick();
    reset_n = 1'b1;
    count_busy(n, sawv);
    chk("rst_clear_cycles", 36'(n), 36'd16);
    read_check(0, 5, 36'h2A5, "rst_clear_addr5");

    // Wait for the deep instance to finish clearing
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (!busy[2]) break;
    end
    chk("deep_clear_done", {35'b0, busy[2]}, 36'd0);
    read_check(2, 1023, 36'h9_C3A5_5A3C, "deep_clear_top");
    wr(2, 1023, 36'h9_8765_4321);
    read_check(2, 1023, 36'h9_8765_4321, "deep_top");
    read_check(2, 0, 36'h9_C3A5_5A3C, "deep_addr0");
    wr(1, 3, 36'd0);
    read_check(1, 3, 36'd0, "narrow_top");
    read_check(1, 2, 36'd1, "narrow_cleared");

    // Random traffic on all instances, biased to the end addresses
    repeat (400) begin
      for (int g = 0; g < NI; g++) begin
        wr_en[g]   = 1'($urandom % 2);
        rd_en[g]   = 1'($urandom % 2);
        wr_addr[g] = pick(g);
        rd_addr[g] = ($urandom % 4 == 0) ? wr_addr[g] : pick(g);
        wr_data[g] = {4'($urandom), 32'($urandom)};
      end
      tick();
    end
    for (int g = 0; g < NI; g++) begin
      wr_en[g] = 1'b0; rd_en[g] = 1'b0;
    end
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
